mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none; bus widths are fixed as listed below.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global pause; 0 freezes the block.
REQ-005 if_req  input  1  fetch request, held high until if_done.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_data  output  32  fetched word, little-endian; valid while if_done=1.
REQ-008 if_done  output  1  one-cycle fetch completion pulse.
REQ-009 dm_req  input  1  data request, held high until dm_done.
REQ-010 dm_wr  input  1  1=store, 0=load.
REQ-011 dm_size  input  2  0=byte, 1=half, 2 or 3=word; N = 1/2/4 bytes.
REQ-012 dm_addr  input  32  data byte address; unaligned permitted.
REQ-013 dm_wdata  input  32  store data; byte i = dm_wdata[8i+7:8i].
REQ-014 dm_rdata  output  32  load data, zero-extended; valid while dm_done=1.
REQ-015 dm_done  output  1  one-cycle data completion pulse.
REQ-016 mem_din  input  8  RAM read byte; registered RAM, data for mem_a of cycle t appears in cycle t+1.
REQ-017 mem_dout  output  8  RAM write byte.
REQ-018 mem_a  output  32  RAM byte address.
REQ-019 mem_wr  output  1  1=write mem_dout at mem_a this cycle.

Function
REQ-020 States SHALL be IDLE, READ, WRITE, DONE.
REQ-021 IDLE samples requests each edge; dm_req has priority over if_req when both are high; the accept edge latches the address, size, and write data.
REQ-022 READ: the cycles c1..cN after the accept edge drive mem_a=addr+i for i=0..N-1 with mem_wr=0; byte i SHALL be captured from mem_din in cycle c(i+2).
REQ-023 Read completion: the done pulse and data are asserted in cycle c(N+2), so a word fetch completes in c6.
REQ-024 WRITE: cycles c1..cN drive mem_wr=1, mem_a=addr+i, and mem_dout=byte i; done SHALL pulse in c(N+1) with mem_wr=0.
REQ-025 DONE lasts exactly one cycle and then returns to IDLE; a request held high after done is treated as a new request and accepted no earlier than the IDLE edge.
REQ-026 Address arithmetic SHALL be 32-bit modulo; 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-027 For N<4, unused dm_rdata bits SHALL be 0.
REQ-028 In IDLE and DONE: mem_wr=0, and mem_a and mem_dout hold their last values.
REQ-029 While rdy_in=0: state, counters, and captured bytes are frozen; mem_wr=0; no capture occurs; no done pulse is issued; a pending done is deferred until rdy_in=1.
REQ-030 After a pause in READ, issue SHALL restart at the lowest uncaptured byte index, so no byte is lost or duplicated.
REQ-031 After a pause in WRITE, the controller SHALL continue at the next unwritten byte.
REQ-032 Request inputs changing mid-transfer SHALL NOT affect the latched transfer.

Reset
REQ-033 rst_in=1 SHALL immediately force IDLE with mem_a=0, mem_dout=0, mem_wr=0, if_data=0, if_done=0, dm_rdata=0, dm_done=0.
REQ-034 A transfer aborted by reset SHALL NOT produce a done pulse; a write aborted by reset may leave a partially written word in RAM.
REQ-035 After rst_in falls, the first accept SHALL occur no earlier than the first rising edge.

Verification
REQ-036 RAM[0x100..0x103]=13,05,00,00; if_req, if_addr=0x100 -> mem_a sequence 0x100..0x103, if_done in c6, if_data=0x00000513.
REQ-037 dm_req store, dm_size=1, dm_addr=0x201, dm_wdata=0xA1B2C3D4 -> mem_wr=1 for 2 cycles, (0x201,D4), (0x202,C3); dm_done in c3; RAM[0x203] unchanged.
REQ-038 if_req and dm_req (load byte at 0x10, RAM=0x8F) raised together -> dm served first, dm_rdata=0x0000008F; if_done follows after the DONE/IDLE turnaround.
REQ-039 Word load from 0x300 with rdy_in=0 for 3 cycles starting in c3 -> mem_wr=0 throughout, bytes re-issued from the first uncaptured byte, dm_rdata correct, dm_done delayed by the pause length plus 1.
REQ-040 rst_in pulsed in c3 of a word store at 0x400 -> all outputs 0 next cycle, no dm_done; a new request after reset completes normally.
REQ-041 Word load at 0xFFFFFFFE -> mem_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: fetch and data ports share one
// registered 8-bit RAM, transfers of 1/2/4 bytes, pausable via rdy_in.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  dout_q, dout_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] buf_q, buf_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  iss_q, iss_d;
  logic [2:0]  cap_q, cap_d;
  logic        vld_q, vld_d;
  logic        dsel_q, dsel_d;
  logic [2:0]  nxt;
  logic        fin;

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      base_q  <= '0;
      mem_a_q <= '0;
      dout_q  <= '0;
      wdat_q  <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      cap_q   <= '0;
      vld_q   <= 1'b0;
      dsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mem_a_q <= mem_a_d;
      dout_q  <= dout_d;
      wdat_q  <= wdat_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      vld_q   <= vld_d;
      dsel_q  <= dsel_d;
    end
  end

  // Next-state: accept, byte issue/capture, pause rewind, completion
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mem_a_d = mem_a_q;
    dout_d  = dout_q;
    wdat_d  = wdat_q;
    buf_d   = buf_q;
    len_d   = len_q;
    iss_d   = iss_q;
    cap_d   = cap_q;
    vld_d   = vld_q;
    dsel_d  = dsel_q;
    nxt     = iss_q + 3'd1;
    unique case (state_q)
      IDLE: begin
        if (rdy_in && (dm_req || if_req)) begin
          dsel_d  = dm_req;
          base_d  = dm_req ? dm_addr : if_addr;
          mem_a_d = dm_req ? dm_addr : if_addr;
          wdat_d  = dm_wdata;
          buf_d   = '0;
          iss_d   = '0;
          cap_d   = '0;
          vld_d   = 1'b0;
          len_d   = 3'd4;
          if (dm_req && dm_size == 2'd0) len_d = 3'd1;
          if (dm_req && dm_size == 2'd1) len_d = 3'd2;
          if (dm_req && dm_wr) begin
            dout_d  = dm_wdata[7:0];
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (rdy_in) begin
          vld_d = iss_q < len_q;
          if (iss_q < len_q) begin
            iss_d = nxt;
            if (nxt < len_q) mem_a_d = base_q + {29'b0, nxt};
          end
          if (vld_q) begin
            buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
            cap_d = cap_q + 3'd1;
            if (cap_q + 3'd1 == len_q) state_d = DONE;
          end
        end else begin
          // Data returning during a pause is dropped; re-issue from
          // the lowest byte not yet captured.
          vld_d   = 1'b0;
          iss_d   = cap_q;
          mem_a_d = base_q + {29'b0, cap_q};
        end
      end
      WRITE: begin
        if (rdy_in) begin
          iss_d = nxt;
          if (nxt == len_q) begin
            state_d = DONE;
          end else begin
            mem_a_d = base_q + {29'b0, nxt};
            dout_d  = wdat_q[{nxt[1:0], 3'b000} +: 8];
          end
        end
      end
      DONE: begin
        if (rdy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: done pulses and data only while unpaused
  always_comb begin
    fin      = (state_q == DONE) && rdy_in;
    if_done  = fin && !dsel_q;
    dm_done  = fin && dsel_q;
    if_data  = if_done ? buf_q : 32'h0;
    dm_rdata = dm_done ? buf_q : 32'h0;
    mem_wr   = (state_q == WRITE) && rdy_in;
    mem_a    = mem_a_q;
    mem_dout = dout_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered byte RAM model.
// Expected values are hand-computed per scenario.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_done, dm_req, dm_wr, dm_done;
  logic [31:0] if_addr, if_data, dm_addr, dm_wdata, dm_rdata, mem_a;
  logic [1:0]  dm_size;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr;

  logic [7:0]  ram [0:4095];
  logic        pk_en;
  logic [11:0] pk_a;
  logic [7:0]  pk_d;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_log [0:31];
  logic        w_log [0:31];
  logic [7:0]  d_log [0:31];
  int          done_c;
  int          any_wr;
  int          seen;
  logic        got_dm;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_data  (if_data),
    .if_done  (if_done),
    .dm_req   (dm_req),
    .dm_wr    (dm_wr),
    .dm_size  (dm_size),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr)
  );

  always @(posedge clk) begin
    if (pk_en) ram[pk_a] <= pk_d;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pk_a  = a;
    pk_d  = d;
    pk_en = 1'b1;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  task automatic xfer(input int maxc, input int ps, input int pl);
    done_c = -1;
    any_wr = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk);
      #1 rdy = !(c >= ps && c < ps + pl);
      @(negedge clk);
      a_log[c] = mem_a;
      w_log[c] = mem_wr;
      d_log[c] = mem_dout;
      if (mem_wr) any_wr++;
      if (if_done || dm_done) begin
        done_c = c;
        got_dm = dm_done;
        rdata  = dm_done ? dm_rdata : if_data;
        if (dm_done) dm_req = 1'b0;
        else if_req = 1'b0;
        break;
      end
    end
    rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; pk_en = 1'b0; pk_a = '0; pk_d = '0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0;
    dm_size = '0; dm_addr = '0; dm_wdata = '0; got_dm = 1'b0;
    rdata = '0;
    poke(12'h100, 8'h13); poke(12'h101, 8'h05);
    poke(12'h102, 8'h00); poke(12'h103, 8'h00);
    poke(12'h201, 8'h00); poke(12'h202, 8'h00);
    poke(12'h203, 8'h77); poke(12'h010, 8'h8F);
    poke(12'h300, 8'h11); poke(12'h301, 8'h22);
    poke(12'h302, 8'h33); poke(12'h303, 8'h44);
    poke(12'hFFE, 8'h01); poke(12'hFFF, 8'h02);
    poke(12'h000, 8'h03); poke(12'h001, 8'h04);

    // reset state
    @(negedge clk);
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst mem_dout", {24'b0, mem_dout}, 32'h0);
    chk("rst if_done", {31'b0, if_done}, 32'h0);
    chk("rst dm_done", {31'b0, dm_done}, 32'h0);
    chk("rst if_data", if_data, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // fetch word at 0x100
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h100;
    xfer(12, 0, 0);
    chk("fetch a1", a_log[1], 32'h100);
    chk("fetch a2", a_log[2], 32'h101);
    chk("fetch a3", a_log[3], 32'h102);
    chk("fetch a4", a_log[4], 32'h103);
    chk("fetch no wr", any_wr, 0);
    chk("fetch done cyc", done_c, 6);
    chk("fetch port", {31'b0, got_dm}, 32'h0);
    chk("fetch data", rdata, 32'h00000513);

    // half store at 0x201
    @(posedge clk);
    #1 dm_req = 1'b1; dm_wr = 1'b1; dm_size = 2'd1;
    dm_addr = 32'h201; dm_wdata = 32'hA1B2C3D4;
    xfer(12, 0, 0);
    dm_wr = 1'b0;
    chk("st w1", {31'b0, w_log[1]}, 32'h1);
    chk("st a1", a_log[1], 32'h201);
    chk("st d1", {24'b0, d_log[1]}, 32'hD4);
    chk("st w2", {31'b0, w_log[2]}, 32'h1);
    chk("st a2", a_log[2], 32'h202);
    chk("st d2", {24'b0, d_log[2]}, 32'hC3);
    chk("st wr count", any_wr, 2);
    chk("st done cyc", done_c, 3);
    chk("st port", {31'b0, got_dm}, 32'h1);
    chk("ram 201", {24'b0, ram[12'h201]}, 32'hD4);
    chk("ram 202", {24'b0, ram[12'h202]}, 32'hC3);
    chk("ram 203", {24'b0, ram[12'h203]}, 32'h77);

    // simultaneous requests: data side first
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_wr = 1'b0; dm_size = 2'd0; dm_addr = 32'h10;
    xfer(12, 0, 0);
    chk("prio done cyc", done_c, 3);
    chk("prio port", {31'b0, got_dm}, 32'h1);
    chk("prio byte", rdata, 32'h0000008F);
    xfer(14, 0, 0);
    chk("prio if a2", a_log[2], 32'h100);
    chk("prio if cyc", done_c, 7);
    chk("prio if port", {31'b0, got_dm}, 32'h0);
    chk("prio if data", rdata, 32'h00000513);

    // word load with pause in c3..c5
    @(posedge clk);
    #1 dm_req = 1'b1; dm_wr = 1'b0; dm_size = 2'd2; dm_addr = 32'h300;
    xfer(20, 3, 3);
    chk("pause a1", a_log[1], 32'h300);
    chk("pause a2", a_log[2], 32'h301);
    chk("pause a6", a_log[6], 32'h301);
    chk("pause a7", a_log[7], 32'h302);
    chk("pause a8", a_log[8], 32'h303);
    chk("pause no wr", any_wr, 0);
    chk("pause done cyc", done_c, 10);
    chk("pause data", rdata, 32'h44332211);

    // reset in c3 of a word store
    @(posedge clk);
    #1 dm_req = 1'b1; dm_wr = 1'b1; dm_size = 2'd2;
    dm_addr = 32'h400; dm_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1; dm_req = 1'b0; dm_wr = 1'b0;
    @(negedge clk);
    chk("abort mem_a", mem_a, 32'h0);
    chk("abort mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("abort mem_dout", {24'b0, mem_dout}, 32'h0);
    chk("abort dm_done", {31'b0, dm_done}, 32'h0);
    chk("abort dm_rdata", dm_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dm_done || if_done) seen++;
    end
    chk("abort no done", seen, 0);
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h100;
    xfer(12, 0, 0);
    chk("post rst cyc", done_c, 6);
    chk("post rst data", rdata, 32'h00000513);

    // address wrap
    @(posedge clk);
    #1 dm_req = 1'b1; dm_wr = 1'b0; dm_size = 2'd3;
    dm_addr = 32'hFFFFFFFE;
    xfer(12, 0, 0);
    chk("wrap a1", a_log[1], 32'hFFFFFFFE);
    chk("wrap a2", a_log[2], 32'hFFFFFFFF);
    chk("wrap a3", a_log[3], 32'h00000000);
    chk("wrap a4", a_log[4], 32'h00000001);
    chk("wrap done cyc", done_c, 6);
    chk("wrap data", rdata, 32'h04030201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
